mif_arbiter: RTL
================

# mif_arbiter

Parametrised memory interface that gives NUM_CH requesting units (instruction units or similar) shared access to one single-port SRAM. Widths are configurable. Each channel issues store/load requests. The block picks one channel by round-robin arbitration and drives the SRAM read_req/write_req handshake until mem_resp. It then returns a per-channel mem_done pulse, plus read data for loads. It replaces the single-requester, fixed-width memory interface between instruction units and sram_single_port.

## Interface
- NUM_CH, 2: number of requesting channels (≥1).
- ADDR_W, 14: memory address width.
- DATA_W, 16: data width, both directions.
- TIMEOUT_CYC, 64: maximum cycles to wait for mem_resp; used only when the timeout is compiled in.

- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- store  in  NUM_CH  per-channel store request (level).
- load  in  NUM_CH  per-channel load request (level).
- addr  in  NUM_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_CH*DATA_W  per-channel store data, packed the same way.
- mem_done  out  NUM_CH  one-cycle completion pulse for the served channel.
- rdata  out  DATA_W  load data; valid while mem_done is high for a load.
- err  out  NUM_CH  one-cycle timeout flag, coincident with mem_done.
- read_req  out  1  SRAM read request.
- write_req  out  1  SRAM write request.
- addrout  out  ADDR_W  SRAM address.
- datatomem  out  DATA_W  SRAM write data.
- datafrommem  in  DATA_W  SRAM read data.
- mem_resp  in  1  SRAM access complete.

## Operation
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Last-grant pointer = NUM_CH-1, so channel 0 has first priority.
- A channel is requesting when store[i] | load[i].
- If both bits are high on one channel, it is treated as a store and the load is ignored for that grant.
- IDLE:
  - If any channel is requesting, grant the first one found searching upward from last_grant+1 (wrapping).
  - Latch the channel index, operation, addr slice and wdata slice.
  - Go to REQ.
- REQ:
  - Hold read_req (load) or write_req (store) high, with addrout/datatomem driven from the latched values, stable throughout.
  - On mem_resp sampled high: for a load, capture datafrommem into rdata. Go to DONE.
- DONE:
  - mem_done[ch] high for exactly one cycle.
  - Request outputs low.
  - last_grant ← ch.
  - Go to IDLE.
- rdata holds its value until the next load completes; stores do not change it.
- Requester rules:
  - Hold store/load/addr/wdata stable from assertion until mem_done.
  - Deassert on the edge at which mem_done is sampled high.
  - A request still high at the following IDLE sample is a new transaction.
- mem_resp is ignored outside REQ.
- Requests arriving during REQ/DONE wait; they are never dropped.

## Timing
- Minimum latency: request sampled at edge k → read_req/write_req high after edge k. With mem_resp high at edge k+1, mem_done is high between edges k+1 and k+2.
- Back-to-back grants: one idle cycle between a mem_done pulse and the next read_req/write_req.
- Fairness: with all channels continuously requesting, grants rotate 0,1,…,NUM_CH-1,0,…
- Reset mid-transaction: all outputs clear immediately (asynchronously). No mem_done or err is produced for the aborted access; requesters reissue.

## Configuration
- MIF_TIMEOUT_EN defined:
  - A cycle counter runs in REQ.
  - After TIMEOUT_CYC cycles without mem_resp: drop the request, go to DONE, and pulse mem_done[ch] and err[ch] together. rdata is unchanged.
- MIF_TIMEOUT_EN undefined:
  - REQ waits indefinitely.
  - err is tied to 0.
  - No counter is synthesised.

## Structure
- Package mif_pkg holds:
  - the state enum mif_state_t (IDLE, REQ, DONE);
  - the op enum mif_op_t (MIF_LOAD, MIF_STORE);
  - the default width constants.
- Sub-module rr_arbiter (parameter NUM_CH): combinational. Takes the request vector and last-grant pointer; returns the one-hot grant and grant index.

## Test plan
- Load ch0, addr 0x0010, SRAM answers 0xBEEF one cycle later → read_req high with addrout 0x0010; mem_done = 2'b01 for one cycle; rdata = 0xBEEF.
- Store ch1, addr 0x3FFF, wdata 0x1234 → write_req high, addrout 0x3FFF, datatomem 0x1234; mem_done = 2'b10; rdata unchanged.
- Both channels requesting continuously from reset → grant order 0,1,0,1; each grant separated by mem_done and one idle cycle.
- ch0 with store=1 and load=1, wdata 0x00AA → write_req only, datatomem 0x00AA; read_req never asserted.
- reset_n driven low while REQ is waiting on a load → read_req falls without a clock edge; no mem_done. After release, a reissued request completes normally.
- MIF_TIMEOUT_EN, TIMEOUT_CYC=64, mem_resp held low → after 64 REQ cycles, err[0] and mem_done[0] pulse together. Without the macro, read_req stays high past 200 cycles and err stays 0.

Source files
------------

// File: rtl/mif_pkg.sv
// mif_pkg: shared types and default widths for the mif_arbiter block.
//   mif_state_t : controller states (IDLE, REQ, DONE)
//   mif_op_t    : operation latched at grant time (MIF_LOAD, MIF_STORE)
//   MIF_*       : default parameter values for channel count and widths
//   mif_idx_w() : width of a channel index, never below one bit
package mif_pkg;

  localparam int MIF_NUM_CH      = 2;
  localparam int MIF_ADDR_W      = 14;
  localparam int MIF_DATA_W      = 16;
  localparam int MIF_TIMEOUT_CYC = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mif_state_t;

  typedef enum logic {
    MIF_LOAD  = 1'b0,
    MIF_STORE = 1'b1
  } mif_op_t;

  function automatic int mif_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mif_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req     in  NUM_CH  request vector
//   last    in  IDX_W   index of the most recently served channel
//   gnt     out NUM_CH  one-hot grant (all zero when nothing requests)
//   gnt_idx out IDX_W   index of the granted channel
// The search starts at last+1 and wraps, so the channel just served has
// lowest priority on the next pick.
module rr_arbiter
  import mif_pkg::*;
#(
  parameter int NUM_CH = MIF_NUM_CH,
  parameter int IDX_W  = mif_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx
);

  logic             found_hi;
  logic             found_lo;
  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;

  // Two candidates: the lowest requester above last (no wrap needed) and
  // the lowest requester overall (the wrapped choice). Scanning downward
  // lets the final assignment hold the lowest index.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        found_lo = 1'b1;
        idx_lo   = IDX_W'(i);
        if (i > int'(last)) begin
          found_hi = 1'b1;
          idx_hi   = IDX_W'(i);
        end
      end
    end
    gnt_idx = found_hi ? idx_hi : idx_lo;
    gnt     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      gnt[i] = found_lo && (gnt_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/mif_arbiter.sv
// mif_arbiter: shares one single-port SRAM among NUM_CH requesters.
// Optional feature macro: MIF_TIMEOUT_EN (REQ gives up after TIMEOUT_CYC
// cycles without mem_resp and flags err together with mem_done).
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   store/load [NUM_CH]     per-channel level requests (store wins if both)
//   addr, wdata             per-channel packed address / store data
//   mem_done [NUM_CH]       one-cycle completion pulse for the served channel
//   rdata                   last load data, updated only when a load completes
//   err [NUM_CH]            timeout flag, coincident with mem_done
//   read_req, write_req     SRAM request, held through REQ
//   addrout, datatomem      SRAM address / write data, valid during REQ
//   datafrommem, mem_resp   SRAM read data / access complete
//   fsm_state               controller state (mif_state_t encoding) for debug
// Handshake: a requester holds store/load/addr/wdata stable until it samples
// mem_done high and drops the request on that edge; the SRAM side sees
// read_req/write_req held until mem_resp is sampled high in REQ, and
// mem_resp is ignored in every other state.
module mif_arbiter
  import mif_pkg::*;
#(
  parameter int NUM_CH      = MIF_NUM_CH,
  parameter int ADDR_W      = MIF_ADDR_W,
  parameter int DATA_W      = MIF_DATA_W,
  parameter int TIMEOUT_CYC = MIF_TIMEOUT_CYC
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        store,
  input  logic [NUM_CH-1:0]        load,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        mem_done,
  output logic [DATA_W-1:0]        rdata,
  output logic [NUM_CH-1:0]        err,
  output logic                     read_req,
  output logic                     write_req,
  output logic [ADDR_W-1:0]        addrout,
  output logic [DATA_W-1:0]        datatomem,
  input  logic [DATA_W-1:0]        datafrommem,
  input  logic                     mem_resp,
  output logic [1:0]               fsm_state
);

  localparam int IDX_W = mif_idx_w(NUM_CH);

  mif_state_t        state_q, state_d;
  mif_op_t           op_q, op_d;
  logic [IDX_W-1:0]  ch_q, ch_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [NUM_CH-1:0] gnt_oh;
  logic [IDX_W-1:0]  gnt_idx;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

`ifdef MIF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
`endif

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req     (store | load),
    .last    (last_q),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx)
  );

  // Slice out the granted channel's address and data.
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_oh[i]) begin
        addr_sel  = addr[i*ADDR_W +: ADDR_W];
        wdata_sel = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= MIF_LOAD;
      ch_q    <= '0;
      last_q  <= IDX_W'(NUM_CH - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MIF_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MIF_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ch_d    = ch_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MIF_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MIF_TIMEOUT_EN
        cnt_d = '0;
        to_d  = 1'b0;
`endif
        if (|gnt_oh) begin
          ch_d    = gnt_idx;
          // A channel raising both store and load is served as a store.
          op_d    = (|(store & gnt_oh)) ? MIF_STORE : MIF_LOAD;
          addr_d  = addr_sel;
          wdata_d = wdata_sel;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_resp) begin
          if (op_q == MIF_LOAD) rdata_d = datafrommem;
          state_d = DONE;
        end
`ifdef MIF_TIMEOUT_EN
        // cnt_q counts completed REQ cycles; the last allowed one ends here.
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        last_d  = ch_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      mem_done[i] = (state_q == DONE) && (ch_q == IDX_W'(i));
    end
  end

`ifdef MIF_TIMEOUT_EN
  assign err = to_q ? mem_done : '0;
`else
  assign err = '0;
`endif

  assign read_req  = (state_q == REQ) && (op_q == MIF_LOAD);
  assign write_req = (state_q == REQ) && (op_q == MIF_STORE);
  assign addrout   = (state_q == REQ) ? addr_q : '0;
  assign datatomem = (state_q == REQ) ? wdata_q : '0;
  assign rdata     = rdata_q;
  assign fsm_state = state_q;

endmodule
